// File: rtl/debug_ctrl_pkg.sv
// debug_ctrl_pkg: FSM encoding and debounce constants shared by the board debugger.
package debug_ctrl_pkg;
    typedef enum logic [1:0] {HALT = 2'd0, STEP = 2'd1, RUN = 2'd2} state_e;
    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int DEBOUNCE_SIM = 4;
endpackage

// File: rtl/debug_ctrl_debounce_bit.sv
// debounce_bit: 2-FF synchronizer plus hold counter; a new level is accepted only after it persists.
module debounce_bit
    import debug_ctrl_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int   CNT_W           = 20,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, stable_q, stable_d, differ, done;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign differ = sync2_q != stable_q;
    assign done   = differ && cnt_q == LAST;
    always_comb begin
        stable_d = done ? sync2_q : stable_q;
        cnt_d    = (differ && !done) ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
    assign stable_o = stable_q;
endmodule

// File: rtl/debug_ctrl.sv
// debug_ctrl: debounces board switches/keys and runs the HALT/STEP/RUN stepping FSM with a PC breakpoint.
module debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [9:0]  swRaw,
    input  logic        keyStepRaw,
    input  logic        keyRunRaw,
    input  logic        brkEnable,
    input  logic [31:0] brkAddr,
    input  logic [31:0] address,
    output logic [9:0]  switches,
    output logic        stepEn,
    output logic        running,
    output logic [15:0] stepCount
);
    logic [11:0] raw, stable;
    logic [1:0]  key_prev_q;
    logic        step_press, run_press, brk_hit, armed_q, armed_d;
    logic [15:0] count_q, count_d;
    state_e      state_q, state_d;
    assign raw = {keyRunRaw, keyStepRaw, swRaw};
    // Keys are active-low, so their stable level resets to released (1).
    for (genvar i = 0; i < 12; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W),
            .RESET_VAL(1'(i >= 10))
        ) u_db (
            .clk_i(Clk),
            .rst_i(Rst),
            .raw_i(raw[i]),
            .stable_o(stable[i])
        );
    end
    assign step_press = key_prev_q[0] & ~stable[10];
    assign run_press  = key_prev_q[1] & ~stable[11];
    assign brk_hit    = brkEnable && armed_q && address == brkAddr;
    assign count_d    = count_q + 16'(stepEn);
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= HALT;
            armed_q    <= 1'b0;
            key_prev_q <= 2'b11;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            key_prev_q <= stable[11:10];
            count_q    <= count_d;
        end
    end
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            HALT: begin
                state_d = run_press ? RUN : step_press ? STEP : HALT;
                armed_d = run_press ? 1'b0 : armed_q;
            end
            STEP: state_d = HALT;
            RUN: begin
                state_d = (run_press || brk_hit) ? HALT : RUN;
                armed_d = armed_q | ~(run_press | brk_hit);
            end
            default: state_d = HALT;
        endcase
    end
    always_comb begin
        running = state_q == RUN;
        stepEn  = state_q == STEP || (running && !run_press && !brk_hit);
    end
    assign switches  = stable[9:0];
    assign stepCount = count_q;
endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: directed stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_debug_ctrl;
    import debug_ctrl_pkg::*;
    typedef struct {
        string       nm;
        logic [9:0]  sw;
        logic        se;
        logic        run;
        logic [15:0] cnt;
    } exp_t;
    logic        clk, Rst, keyStepRaw, keyRunRaw, brkEnable, stepEn, running;
    logic [9:0]  swRaw, switches;
    logic [31:0] brkAddr, address;
    logic [15:0] stepCount;
    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0, n_bad = 0;
    logic [9:0]  sw_model;
    logic [15:0] cnt_model;
    logic        quiet, track_addr, last_es;
    debug_ctrl #(.DEBOUNCE_CYCLES(DEBOUNCE_SIM), .CNT_W(4)) dut (
        .Clk(clk), .Rst(Rst), .swRaw(swRaw), .keyStepRaw(keyStepRaw), .keyRunRaw(keyRunRaw),
        .brkEnable(brkEnable), .brkAddr(brkAddr), .address(address), .switches(switches),
        .stepEn(stepEn), .running(running), .stepCount(stepCount)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #10_000_000;
        n_bad++;
        $display("FAIL timeout: wait expired @%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (switches !== e.sw || stepEn !== e.se || running !== e.run || stepCount !== e.cnt) begin
                n_bad++;
                $display("FAIL %s @%0t: got sw=%h stepEn=%b running=%b cnt=%h, want sw=%h stepEn=%b running=%b cnt=%h",
                         e.nm, $time, switches, stepEn, running, stepCount, e.sw, e.se, e.run, e.cnt);
            end
        end
    end
    task automatic cyc(input logic es, input logic er, input string nm);
        @(posedge clk);
        #1;
        if (track_addr && last_es) address = address + 32'd4;
        last_es = es;
        if (!quiet) q.push_back('{nm, sw_model, es, er, cnt_model});
        if (es) cnt_model = cnt_model + 16'd1;
    endtask
    task automatic cycn(input int n, input logic es, input logic er, input string nm);
        for (int k = 0; k < n; k++) cyc(es, er, nm);
    endtask
    initial begin
        Rst = 1'b1; swRaw = '0; keyStepRaw = 1'b1; keyRunRaw = 1'b1;
        brkEnable = 1'b0; brkAddr = 32'h10; address = '0;
        quiet = 1'b0; track_addr = 1'b0; last_es = 1'b0; sw_model = '0; cnt_model = '0;
        cycn(2, 0, 0, "reset");
        n_cmp++;
        if (switches !== 10'h0 || stepEn !== 1'b0 || running !== 1'b0 || stepCount !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state @%0t: sw=%h stepEn=%b running=%b cnt=%h",
                     $time, switches, stepEn, running, stepCount);
        end
        Rst = 1'b0; swRaw = 10'h3A5;
        cycn(5, 0, 0, "sw_hold");
        sw_model = 10'h3A5;
        cyc(0, 0, "sw_accept");
        swRaw = 10'h3A4; cycn(3, 0, 0, "glitch");
        swRaw = 10'h3A5; cycn(8, 0, 0, "glitch_ignored");
        keyStepRaw = 1'b0; cycn(6, 0, 0, "step_wait"); cyc(1, 0, "step_en"); cycn(3, 0, 0, "step_done");
        keyStepRaw = 1'b1; cycn(10, 0, 0, "step_release");
        keyRunRaw = 1'b0; cycn(6, 0, 0, "run_wait"); cycn(4, 1, 1, "run");
        keyRunRaw = 1'b1; cycn(10, 1, 1, "run");
        keyRunRaw = 1'b0; cycn(5, 1, 1, "run"); cyc(0, 1, "halt_cycle"); cycn(3, 0, 0, "halted");
        keyRunRaw = 1'b1; cycn(6, 0, 0, "run_release");
        brkEnable = 1'b1; address = '0; track_addr = 1'b1; last_es = 1'b0;
        keyRunRaw = 1'b0; cycn(6, 0, 0, "brk_wait"); cyc(1, 1, "brk_run");
        keyRunRaw = 1'b1; cycn(3, 1, 1, "brk_run"); cyc(0, 1, "brk_halt"); cycn(7, 0, 0, "brk_halted");
        keyRunRaw = 1'b0; cycn(6, 0, 0, "resume_wait"); cyc(1, 1, "resume_exec_10");
        keyRunRaw = 1'b1; cycn(8, 1, 1, "resume_run");
        keyRunRaw = 1'b0; cycn(5, 1, 1, "resume_run"); cyc(0, 1, "resume_halt"); cycn(2, 0, 0, "halted2");
        keyRunRaw = 1'b1; cycn(6, 0, 0, "rel"); track_addr = 1'b0; brkEnable = 1'b0;
        keyRunRaw = 1'b0; keyStepRaw = 1'b0; cycn(6, 0, 0, "both_wait"); cyc(1, 1, "both_run_wins");
        keyRunRaw = 1'b1; keyStepRaw = 1'b1; cycn(6, 1, 1, "run");
        keyStepRaw = 1'b0; cycn(8, 1, 1, "step_in_run");
        keyStepRaw = 1'b1; cycn(6, 1, 1, "run");
        keyRunRaw = 1'b0; cycn(5, 1, 1, "run"); cyc(0, 1, "halt3"); cycn(2, 0, 0, "halted3");
        keyRunRaw = 1'b1; cycn(6, 0, 0, "rel");
        keyRunRaw = 1'b0; cycn(6, 0, 0, "wrap_wait"); cyc(1, 1, "wrap_run");
        keyRunRaw = 1'b1;
        quiet = 1'b1;
        while (cnt_model != 16'hFFFE) cyc(1, 1, "");
        quiet = 1'b0;
        cycn(4, 1, 1, "wrap");
        Rst = 1'b1; sw_model = '0; cnt_model = '0; cyc(0, 0, "rst_run");
        Rst = 1'b0; cycn(5, 0, 0, "rst_sw_reacq");
        sw_model = 10'h3A5; cycn(2, 0, 0, "rst_sw_back");
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
